spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
- Decodes the byte stream from spi_slave into system-bus read/write transactions. This gives the MCU access to PET RAM, ROM and I/O over SPI.
- Sits in the clk domain downstream of the SPI byte synchronizer.
- Owns the bus request handshake to the memory arbiter.
- Returns read data to the SPI transmit path.
- Supports address auto-increment within one chip-select frame.

Parameters:
ADDR_WIDTH, 17, width of system bus address (bit 16 comes from command byte bit 0)
TIMEOUT, 255, clk cycles to wait for bus_ack before aborting and flagging error

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
spi_cs_n  input  1  chip select, already synchronized to clk; high = frame inactive
spi_rx  input  8  received byte; stable when spi_rx_valid
spi_rx_valid  input  1  one-clk pulse per completed SPI byte
spi_tx  output  8  byte presented for the next SPI transfer
bus_req  output  1  request to arbiter; held high until bus_ack
bus_we  output  1  1 = write, 0 = read; stable while bus_req
bus_addr  output  ADDR_WIDTH  transaction address; stable while bus_req
bus_wdata  output  8  write data; stable while bus_req
bus_rdata  input  8  read data; valid in the cycle bus_ack is high on a read
bus_ack  input  1  one-clk completion pulse from arbiter
busy  output  1  high from first command byte until frame end and no bus_req outstanding
err  output  1  sticky: overrun or timeout; cleared only by reset or a CLR_ERR command

Behaviour:
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, spi_tx=8'h00, busy=0, err=0. State=CMD. Reset mid-transaction drops bus_req the next cycle; the arbiter treats an unacked drop as cancel.
- Command byte (first byte after spi_cs_n falls), cmd[7:6]:
  - 2'b10: WRITE
  - 2'b11: READ
  - 2'b01: SET_ADDR
  - 2'b00 with cmd[5:0]=6'h3F: CLR_ERR
  - any other 2'b00 code: NOP
- Address: cmd[0] = address bit 16, then addr_hi byte, then addr_lo byte. Big-endian.
- States:
  - CMD: on a valid byte, latch cmd; CLR_ERR clears err and stays in CMD; NOP stays in CMD; else go to AHI.
  - AHI: latch addr[15:8]; go to ALO.
  - ALO: latch addr[7:0]. WRITE goes to DATA. READ goes to RD_REQ. SET_ADDR goes to HOLD (ignores further bytes until frame end).
  - DATA: each valid byte loads bus_wdata, asserts bus_req with bus_we=1, and goes to WR_WAIT.
  - WR_WAIT: on bus_ack, drop bus_req the same edge, addr <= addr+1, return to DATA.
  - RD_REQ: assert bus_req with bus_we=0; go to RD_WAIT.
  - RD_WAIT: on bus_ack, spi_tx <= bus_rdata, drop bus_req, addr <= addr+1, go to RD_NEXT.
  - RD_NEXT: each valid byte (content ignored, dummy clock) issues the next read via RD_REQ. spi_tx therefore always holds the byte at the previous address.
- Latency: bus_req rises 1 clk after the triggering spi_rx_valid. Auto-increment is applied in the ack cycle.
- Address arithmetic: modulo 2^ADDR_WIDTH. 17'h1FFFF+1 wraps to 0.
- Overrun: spi_rx_valid while in WR_WAIT/RD_WAIT sets err. The byte is discarded and the current transaction continues.
- Timeout: counter resets on each bus_req rise. If TIMEOUT cycles pass without ack: drop bus_req, set err, go to HOLD.
- Frame end: spi_cs_n high in any state returns to CMD.
  - If bus_req is outstanding, it is held until bus_ack (or timeout) first.
  - spi_tx is retained.
  - A new frame cannot begin decoding until that completes; bytes arriving meanwhile set err.
- Simultaneous bus_ack and spi_rx_valid in a WAIT state: the ack is processed and the byte counts as overrun.
- Simultaneous spi_cs_n rise and spi_rx_valid: the byte is processed first; frame end is handled next cycle.
- busy=1 when state≠CMD or bus_req=1.

Test Plan:
- Write: frame 80 12 34 AA BB -> two bus writes, addr 0x01234 data AA, then 0x01235 data BB. bus_req low after final ack; busy falls after cs_n high.
- Read with auto-increment: mem[0x1FFFF]=5A, mem[0x00000]=C3; frame C1 FF FF 00 00 -> reads at 0x1FFFF then 0x00000 (wrap). spi_tx=5A after the first ack, C3 after the second.
- Overrun: arbiter delays ack 40 clks; send 80 00 10 11 22 back-to-back -> err=1. Only 11 is written to 0x00010; 22 is dropped.
- Timeout and clear: arbiter never acks; frame 80 00 00 55 -> bus_req drops after 255 clks, err=1. Next frame 3F -> err=0.
- Mid-frame abort: raise cs_n after C0 12 -> no bus_req. Next frame 80 00 01 77 -> write 77 to 0x00001.
- Reset during WR_WAIT -> bus_req=0 and state CMD the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: turns the byte stream of one chip-select frame into
// system-bus reads and writes with address auto-increment and an error flag.
module spi_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_n,
  input  logic [7:0]            spi_rx,
  input  logic                  spi_rx_valid,
  output logic [7:0]            spi_tx,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;

  // Read requests are issued on the edge that leaves ALO/RD_NEXT, so there is no
  // separate request state: bus_req rises one clock after the triggering byte.
  typedef enum logic [2:0] {
    StCmd, StAhi, StAlo, StData, StWrWait, StRdWait, StRdNext, StHold
  } state_t;

  state_t          state;
  logic [1:0]      op;
  logic            a16;
  logic [CntW-1:0] tmo_cnt;
  logic            tmo_hit;

  assign tmo_hit = (tmo_cnt == CntW'(TIMEOUT - 1));
  assign busy    = (state != StCmd) || bus_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StCmd;
      op        <= OpNop;
      a16       <= 1'b0;
      tmo_cnt   <= '0;
      spi_tx    <= 8'h00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      err       <= 1'b0;
    end else begin
      unique case (state)
        StCmd: begin
          if (spi_rx_valid) begin
            op  <= spi_rx[7:6];
            a16 <= spi_rx[0];
            if (spi_rx[7:6] == OpNop) begin
              if (spi_rx[5:0] == 6'h3F) err <= 1'b0;
            end else begin
              state <= StAhi;
            end
          end
        end

        StAhi: begin
          if (spi_rx_valid) begin
            bus_addr <= ADDR_WIDTH'({a16, spi_rx, bus_addr[7:0]});
            state    <= StAlo;
          end else if (spi_cs_n) begin
            state <= StCmd;
          end
        end

        StAlo: begin
          if (spi_rx_valid) begin
            bus_addr <= ADDR_WIDTH'({a16, bus_addr[15:8], spi_rx});
            unique case (op)
              OpWrite: state <= StData;
              OpRead: begin
                bus_req <= 1'b1;
                bus_we  <= 1'b0;
                tmo_cnt <= '0;
                state   <= StRdWait;
              end
              OpSet:   state <= StHold;
              default: state <= StCmd;
            endcase
          end else if (spi_cs_n) begin
            state <= StCmd;
          end
        end

        StData: begin
          if (spi_rx_valid) begin
            bus_wdata <= spi_rx;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            tmo_cnt   <= '0;
            state     <= StWrWait;
          end else if (spi_cs_n) begin
            state <= StCmd;
          end
        end

        StWrWait, StRdWait: begin
          // Any byte while a transaction is outstanding is an overrun, even on the
          // ack cycle or while draining after the frame has ended.
          if (spi_rx_valid) err <= 1'b1;
          if (bus_ack) begin
            bus_req  <= 1'b0;
            bus_addr <= bus_addr + ADDR_WIDTH'(1);
            if (state == StRdWait) spi_tx <= bus_rdata;
            if (spi_cs_n)              state <= StCmd;
            else if (state == StWrWait) state <= StData;
            else                       state <= StRdNext;
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            state   <= spi_cs_n ? StCmd : StHold;
          end else begin
            tmo_cnt <= tmo_cnt + CntW'(1);
          end
        end

        StRdNext: begin
          if (spi_rx_valid) begin
            bus_req <= 1'b1;
            bus_we  <= 1'b0;
            tmo_cnt <= '0;
            state   <= StRdWait;
          end else if (spi_cs_n) begin
            state <= StCmd;
          end
        end

        StHold: begin
          if (spi_cs_n) state <= StCmd;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: table of single-transaction frames plus directed
// sequences for auto-increment, overrun, timeout, abort and reset.
module tb_spi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_rx_valid = 1'b0;
  logic [7:0]  spi_tx;
  logic        bus_req;
  logic        bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_ack = 1'b0;
  logic        busy;
  logic        err;

  spi_cmd_sequencer #(.ADDR_WIDTH(17), .TIMEOUT(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_cs_n     (spi_cs_n),
    .spi_rx       (spi_rx),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx       (spi_tx),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  data;
  } txn_t;

  // bytes are sent MSB first; n = number of bytes used
  typedef struct packed {
    logic [31:0] bytes;
    logic [2:0]  n;
    logic        exp_n;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          ack_dly = 2;
  bit          ack_never = 1'b0;
  int          wcnt = 0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  bit [7:0]    mem [int unsigned];
  txn_t        log_q [$];
  vec_t        vecs [7];

  // Arbiter/memory model, acting on the falling edge so bus_ack is stable at posedge.
  always @(negedge clk) begin
    if (bus_req && !req_prev) req_rises++;
    req_prev = bus_req;
    if (bus_ack) begin
      bus_ack = 1'b0;
      wcnt = 0;
    end else if (bus_req && !ack_never) begin
      wcnt++;
      if (wcnt >= ack_dly) begin
        if (bus_we) begin
          mem[32'(bus_addr)] = bus_wdata;
          log_q.push_back('{1'b1, bus_addr, bus_wdata});
        end else begin
          bus_rdata = mem.exists(32'(bus_addr)) ? mem[32'(bus_addr)] : 8'hEE;
          log_q.push_back('{1'b0, bus_addr, bus_rdata});
        end
        bus_ack = 1'b1;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    spi_rx = b;
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    spi_cs_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (bus_req && n < bound) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, bus_req}, 32'd0);
  endtask

  task automatic chk_txn(input string name, input int idx, input logic we,
                         input logic [16:0] addr, input logic [7:0] data);
    txn_t t;
    t = (idx < log_q.size()) ? log_q[idx] : '{1'bx, 17'hx, 8'hx};
    chk({name, "_we"}, {31'd0, t.we}, {31'd0, we});
    chk({name, "_addr"}, {15'd0, t.addr}, {15'd0, addr});
    chk({name, "_data"}, {24'd0, t.data}, {24'd0, data});
  endtask

  initial begin
    int cnt;
    int rises;
    mem[32'h00100] = 8'h3C;
    mem[32'h1ABCD] = 8'h96;
    mem[32'h1FFFF] = 8'h5A;
    mem[32'h00000] = 8'hC3;

    vecs[0] = '{32'h801234AA, 3'd4, 1'b1, 1'b1, 17'h01234, 8'hAA};
    vecs[1] = '{32'h8100055B, 3'd4, 1'b1, 1'b1, 17'h10005, 8'h5B};
    vecs[2] = '{32'hC0010000, 3'd3, 1'b1, 1'b0, 17'h00100, 8'h3C};
    vecs[3] = '{32'hC1ABCD00, 3'd3, 1'b1, 1'b0, 17'h1ABCD, 8'h96};
    vecs[4] = '{32'h41223344, 3'd4, 1'b0, 1'b0, 17'h00000, 8'h00};
    vecs[5] = '{32'h052A0000, 3'd2, 1'b0, 1'b0, 17'h00000, 8'h00};
    vecs[6] = '{32'hC0123400, 3'd3, 1'b1, 1'b0, 17'h01234, 8'hAA};

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", {15'd0, bus_addr}, 32'd0);
    chk("rst_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("rst_tx", {24'd0, spi_tx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Table of single-transaction frames
    for (int v = 0; v < 7; v++) begin
      logic [31:0] bs;
      bs = vecs[v].bytes;
      log_q.delete();
      frame_start();
      for (int i = 0; i < int'(vecs[v].n); i++) send_byte(bs[31 - 8*i -: 8], 8);
      frame_end();
      chk($sformatf("vec%0d_count", v), log_q.size(), {31'd0, vecs[v].exp_n});
      if (vecs[v].exp_n) begin
        chk_txn($sformatf("vec%0d", v), 0, vecs[v].exp_we, vecs[v].exp_addr,
                vecs[v].exp_data);
        if (!vecs[v].exp_we)
          chk($sformatf("vec%0d_tx", v), {24'd0, spi_tx}, {24'd0, vecs[v].exp_data});
      end
      chk($sformatf("vec%0d_err", v), {31'd0, err}, 32'd0);
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // Two writes with auto-increment; busy holds until frame end
    log_q.delete();
    frame_start();
    send_byte(8'h80, 8); send_byte(8'h12, 8); send_byte(8'h34, 8);
    send_byte(8'hAA, 8); send_byte(8'hBB, 8);
    chk("wr2_count", log_q.size(), 32'd2);
    chk_txn("wr2_t0", 0, 1'b1, 17'h01234, 8'hAA);
    chk_txn("wr2_t1", 1, 1'b1, 17'h01235, 8'hBB);
    chk("wr2_req_low", {31'd0, bus_req}, 32'd0);
    chk("wr2_busy_in_frame", {31'd0, busy}, 32'd1);
    frame_end();
    chk("wr2_busy_after", {31'd0, busy}, 32'd0);

    // Read with address wrap
    log_q.delete();
    frame_start();
    send_byte(8'hC1, 8); send_byte(8'hFF, 8); send_byte(8'hFF, 8);
    chk("rdw_tx0", {24'd0, spi_tx}, 32'h5A);
    send_byte(8'h00, 8);
    chk("rdw_tx1", {24'd0, spi_tx}, 32'hC3);
    send_byte(8'h00, 8);
    frame_end();
    chk_txn("rdw_t0", 0, 1'b0, 17'h1FFFF, 8'h5A);
    chk_txn("rdw_t1", 1, 1'b0, 17'h00000, 8'hC3);
    chk_txn("rdw_t2", 2, 1'b0, 17'h00001, 8'hEE);

    // Overrun: second data byte lands while the write is outstanding
    log_q.delete();
    ack_dly = 40;
    frame_start();
    send_byte(8'h80, 8); send_byte(8'h00, 8); send_byte(8'h10, 8);
    send_byte(8'h11, 2);
    send_byte(8'h22, 0);
    wait_idle(100);
    repeat (4) tick();
    frame_end();
    ack_dly = 2;
    chk("ovr_count", log_q.size(), 32'd1);
    chk_txn("ovr_t0", 0, 1'b1, 17'h00010, 8'h11);
    chk("ovr_err", {31'd0, err}, 32'd1);
    frame_start();
    send_byte(8'h3F, 4);
    frame_end();
    chk("ovr_clr", {31'd0, err}, 32'd0);

    // Timeout: no ack ever
    log_q.delete();
    ack_never = 1'b1;
    frame_start();
    send_byte(8'h80, 4); send_byte(8'h00, 4); send_byte(8'h00, 4);
    send_byte(8'h55, 0);
    chk("tmo_req_rise", {31'd0, bus_req}, 32'd1);
    cnt = 0;
    while (bus_req && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", cnt, 32'd255);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_busy_hold", {31'd0, busy}, 32'd1);
    frame_end();
    ack_never = 1'b0;
    chk("tmo_count", log_q.size(), 32'd0);
    frame_start();
    send_byte(8'h3F, 4);
    frame_end();
    chk("tmo_clr", {31'd0, err}, 32'd0);

    // Mid-frame abort, then a normal write
    log_q.delete();
    rises = req_rises;
    frame_start();
    send_byte(8'hC0, 4); send_byte(8'h12, 4);
    frame_end();
    chk("abort_no_req", req_rises - rises, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    frame_start();
    send_byte(8'h80, 8); send_byte(8'h00, 8); send_byte(8'h01, 8); send_byte(8'h77, 8);
    frame_end();
    chk("abort_count", log_q.size(), 32'd1);
    chk_txn("abort_wr", 0, 1'b1, 17'h00001, 8'h77);

    // Reset while a write is outstanding
    ack_dly = 40;
    frame_start();
    send_byte(8'h80, 4); send_byte(8'h00, 4); send_byte(8'h02, 4);
    send_byte(8'h99, 3);
    chk("rstw_req_pre", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_req", {31'd0, bus_req}, 32'd0);
    chk("rstw_we", {31'd0, bus_we}, 32'd0);
    chk("rstw_addr", {15'd0, bus_addr}, 32'd0);
    chk("rstw_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("rstw_tx", {24'd0, spi_tx}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    frame_end();
    ack_dly = 2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
